// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU pipeline types and constants for hazard control
package cpu_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE    = 2'd0,
    HZ_MUL_RUN = 2'd1,
    HZ_MUL_WB  = 2'd2
  } hz_state_e;

  localparam int unsigned MUL_LAT_DEFAULT = 32;
  localparam logic [4:0]  REG_ZERO        = 5'd0;

endpackage

// File: rtl/hz_loaduse_detect.sv
// rtl/hz_loaduse_detect.sv - combinational load-use hazard compare of EX load target vs ID sources
module hz_loaduse_detect
  import cpu_pkg::*;
(
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       hazard_o
);

  // r0 is hardwired, so a load targeting it never creates a dependency
  assign hazard_o = ex_memread_i && (ex_rt_i != REG_ZERO) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush owner: multiply sequencing, load-use, branch squash
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_is_mult,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mul_start,
  output logic        mul_busy,
  output logic        hilo_we
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(MUL_LAT - 1);

  hz_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lu_hazard;
  logic       mul_stall;
  logic       lu_stall;
  logic       stall;

  hz_loaduse_detect u_loaduse (
    .ex_memread_i (ex_memread),
    .ex_rt_i      (ex_rt),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .hazard_o     (lu_hazard)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_IDLE: begin
        if (ex_is_mult) begin
          state_d = HZ_MUL_RUN;
          cnt_d   = '0;
        end
      end
      HZ_MUL_RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = HZ_MUL_WB;
        end
      end
      HZ_MUL_WB: begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset overrides everything so a discarded multiply never leaks a HI/LO write
  always_comb begin
    mul_stall = !rst && (((state_q == HZ_IDLE) && ex_is_mult) || (state_q == HZ_MUL_RUN));
    lu_stall  = !rst && !mul_stall && lu_hazard &&
                ((state_q == HZ_IDLE) || (state_q == HZ_MUL_WB));
    stall     = mul_stall || lu_stall;
  end

  // A squashed branch stays in the frozen ID stage and re-asserts after the stall
  assign pc_en      = !stall;
  assign ifid_en    = !stall;
  assign idex_flush = stall;
  assign ifid_flush = !rst && branch_taken && !stall;
  assign mul_start  = !rst && (state_q == HZ_IDLE) && ex_is_mult;
  assign mul_busy   = !rst && ((state_q == HZ_MUL_RUN) || (state_q == HZ_MUL_WB));
  assign hilo_we    = !rst && (state_q == HZ_MUL_WB);

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!pc_en && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (ifid_flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int LAT = 32;

  // {pc_en, ifid_en, ifid_flush, idex_flush, mul_start, mul_busy, hilo_we}
  localparam logic [6:0] O_IDLE   = 7'b1100000;
  localparam logic [6:0] O_START  = 7'b0001100;
  localparam logic [6:0] O_RUN    = 7'b0001010;
  localparam logic [6:0] O_WB     = 7'b1100011;
  localparam logic [6:0] O_WB_BR  = 7'b1110011;
  localparam logic [6:0] O_WB_LU  = 7'b0001011;
  localparam logic [6:0] O_LU     = 7'b0001000;
  localparam logic [6:0] O_BR     = 7'b1110000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       ex_memread = 1'b0;
  logic [4:0] ex_rt = '0;
  logic       ex_is_mult = 1'b0;
  logic       branch_taken = 1'b0;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, mul_start, mul_busy, hilo_we;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  logic [6:0] outv;

  logic [6:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  assign outv = {pc_en, ifid_en, ifid_flush, idex_flush, mul_start, mul_busy, hilo_we};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .ex_is_mult   (ex_is_mult),
    .branch_taken (branch_taken),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .mul_start    (mul_start),
    .mul_busy     (mul_busy),
    .hilo_we      (hilo_we)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_memread = 1'b0; ex_rt = '0;
    ex_is_mult = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(O_IDLE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outv !== e) begin
        n_bad++;
        $display("FAIL reset c%0d: got %b want %b", c, outv, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multiply();
    logic [6:0] e;
    int stalls;
    stalls = 0;
    for (int c = 0; c < 46; c++) begin
      clear_inputs();
      ex_is_mult   = (c == 10) || (c == 30) || (c == 10 + LAT + 1);
      branch_taken = (c == 20) || (c == 10 + LAT + 1);
      if (c == 25) begin
        ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
      end
      if (c < 10)              e = O_IDLE;
      else if (c == 10)        e = O_START;
      else if (c <= 10 + LAT)  e = O_RUN;
      else if (c == 11 + LAT)  e = O_WB_BR;
      else                     e = O_IDLE;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      if (!pc_en) stalls++;
      n_cmp++;
      if (outv !== e) begin
        n_bad++;
        $display("FAIL multiply c%0d: got %b want %b", c, outv, e);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    n_cmp++;
    if (stalls !== LAT + 1) begin
      n_bad++;
      $display("FAIL multiply_stall_len: got %0d want %0d", stalls, LAT + 1);
    end
  endtask

  task automatic test_loaduse();
    // {memread, ex_rt, id_rs, id_rt, branch}, expected
    logic [16:0] stim [9];
    logic [6:0]  expv [9];
    logic [6:0]  e;
    stim[0] = {1'b1, 5'd5, 5'd0, 5'd5, 1'b0}; expv[0] = O_LU;
    stim[1] = {1'b0, 5'd5, 5'd0, 5'd5, 1'b0}; expv[1] = O_IDLE;
    stim[2] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b0}; expv[2] = O_IDLE;
    stim[3] = {1'b1, 5'd7, 5'd7, 5'd3, 1'b0}; expv[3] = O_LU;
    stim[4] = {1'b0, 5'd7, 5'd7, 5'd7, 1'b0}; expv[4] = O_IDLE;
    stim[5] = {1'b1, 5'd9, 5'd3, 5'd4, 1'b0}; expv[5] = O_IDLE;
    stim[6] = {1'b0, 5'd0, 5'd0, 5'd0, 1'b1}; expv[6] = O_BR;
    stim[7] = {1'b1, 5'd5, 5'd0, 5'd5, 1'b1}; expv[7] = O_LU;
    stim[8] = {1'b0, 5'd5, 5'd0, 5'd5, 1'b1}; expv[8] = O_BR;
    for (int i = 0; i < 9; i++) begin
      {ex_memread, ex_rt, id_rs, id_rt, branch_taken} = stim[i];
      ex_is_mult = 1'b0;
      exp_q.push_back(expv[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outv !== e) begin
        n_bad++;
        $display("FAIL loaduse_branch i%0d: got %b want %b", i, outv, e);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    for (int c = 0; c < 2 * LAT + 6; c++) begin
      clear_inputs();
      ex_is_mult = (c == 0) || (c == LAT + 2);
      if (c == LAT + 1) begin
        ex_memread = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
      end
      if (c == 0)                      e = O_START;
      else if (c <= LAT)               e = O_RUN;
      else if (c == LAT + 1)           e = O_WB_LU;
      else if (c == LAT + 2)           e = O_START;
      else if (c <= 2 * LAT + 2)       e = O_RUN;
      else if (c == 2 * LAT + 3)       e = O_WB;
      else                             e = O_IDLE;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (outv !== e) begin
        n_bad++;
        $display("FAIL back_to_back c%0d: got %b want %b", c, outv, e);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    for (int c = 0; c < LAT + 10; c++) begin
      clear_inputs();
      ex_is_mult = (c == 0);
      rst = (c == 16);
      if (c != 16) begin
        if (c == 0)       e = O_START;
        else if (c < 16)  e = O_RUN;
        else              e = O_IDLE;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (outv !== e) begin
          n_bad++;
          $display("FAIL reset_mid c%0d: got %b want %b", c, outv, e);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    clear_inputs();
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic test_perf();
    logic [31:0] e_stall, e_flush;
    apply_reset();
    for (int c = 0; c < LAT + 6; c++) begin
      clear_inputs();
      ex_is_mult = (c == 0);
      if (c == LAT + 3) begin
        ex_memread = 1'b1; ex_rt = 5'd3; id_rt = 5'd3;
      end
      branch_taken = (c == LAT + 4);
      @(posedge clk); #1;
    end
    clear_inputs();
    e_stall = 32'd34;
    e_flush = 32'd1;
    @(negedge clk);
    n_cmp++;
    if (perf_stall_cnt !== e_stall) begin
      n_bad++;
      $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, e_stall);
    end
    n_cmp++;
    if (perf_flush_cnt !== e_flush) begin
      n_bad++;
      $display("FAIL perf_flush: got %0d want %0d", perf_flush_cnt, e_flush);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_multiply();
    test_loaduse();
    test_back_to_back();
    test_reset_mid();
`ifdef PIPE_HAZARD_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipelined CPU. It sequences the multi-cycle multiply unit, detects load-use hazards and squashes wrong-path fetches on taken branches. It drives the enable and flush controls of the PC, IF/ID and ID/EX registers. It replaces the ad-hoc stall counters currently spread across individual pipeline registers with a single owner of pipeline freeze decisions.

## Interface
- MUL_LAT, 32, multiplier busy cycles after start (legal 1..255)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- ex_memread  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- ex_is_mult  in  1  instruction in EX is MULT/MULTU
- branch_taken  in  1  branch resolved taken in ID this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_flush  out  1  ID/EX clear to bubble
- mul_start  out  1  one-cycle pulse: multiplier latches operands
- mul_busy  out  1  multiplier sequence in progress
- hilo_we  out  1  one-cycle HI/LO write strobe

## Operation
- FSM states: IDLE, MUL_RUN, MUL_WB; 8-bit counter cnt.
- IDLE & ex_is_mult: mul_start=1, stall (see below); next MUL_RUN, cnt<=0.
- MUL_RUN: stall; cnt increments each cycle; when cnt==MUL_LAT-1, next MUL_WB.
- MUL_WB: hilo_we=1, no multiply stall; next IDLE.
- Stall = pc_en=0, ifid_en=0, idex_flush=1.
- mul_busy=1 in MUL_RUN and MUL_WB.
- Load-use (IDLE or MUL_WB only): ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt) -> stall for that cycle.
- Branch: branch_taken & no stall -> ifid_flush=1; PC/IF_ID enables stay 1.
- Priority: rst > multiply stall > load-use > branch. A branch coinciding with a stall is suppressed. ID is frozen, so the branch re-asserts once the stall ends.
- ex_is_mult is ignored outside IDLE.

## Timing
- Control outputs are combinational from state and inputs; state and cnt are registered.
- Multiply: start cycle + MUL_LAT MUL_RUN cycles = MUL_LAT+1 stall cycles. hilo_we comes in the following cycle, during which ID advances.
- Load-use stall: exactly 1 cycle, because the load leaves EX.
- Reset values: state=IDLE, cnt=0. With all inputs 0, outputs are pc_en=1, ifid_en=1, all others 0.
- rst mid-sequence: IDLE at the next edge, no hilo_we. The multiplier result is discarded.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on every cycle with pc_en=0.
  - perf_flush_cnt increments on every cycle with ifid_flush=1.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg holds:
  - the FSM state encoding: HZ_IDLE=2'd0, HZ_MUL_RUN=2'd1, HZ_MUL_WB=2'd2
  - the default MUL_LAT constant
  - REG_ZERO=5'd0
- One sub-module, hz_loaduse_detect: purely combinational comparison of ex_rt against id_rs/id_rt, producing a single hazard bit.

## Test plan
- After rst release, all inputs 0 -> pc_en=ifid_en=1, flushes, mul_start, mul_busy and hilo_we all 0.
- ex_is_mult pulse at cycle 10, MUL_LAT=32:
  - mul_start=1 at cycle 10
  - pc_en=0 for cycles 10..42
  - hilo_we=1 at cycle 43 only
  - pc_en=1 at 43
- ex_memread=1, ex_rt=5, id_rt=5 -> one cycle pc_en=0, idex_flush=1. Repeating with ex_rt=0 -> no stall.
- branch_taken=1 in IDLE -> ifid_flush=1, pc_en=1. Same cycle as the load-use hazard -> ifid_flush=0, stall=1.
- rst asserted at cnt=15 of MUL_RUN -> IDLE next cycle, hilo_we never asserted, pc_en=1.
- With PIPE_HAZARD_PERF_EN: one 32-latency multiply plus one load-use stall -> perf_stall_cnt=34.
